// File: rtl/or1200_mt_rf_pkg.sv
// Shared types and helpers for the multithreaded OR1200 register file.
// The flat storage index is {thread, reg}, so a thread's context is one contiguous block.
package or1200_mt_rf_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } rf_state_e;

  localparam int RF_DEF_NTHREADS = 8;
  localparam int RF_DEF_AW       = 5;

  function automatic int rf_depth(input int nthreads, input int aw);
    return nthreads * (1 << aw);
  endfunction

  localparam int RF_DEF_DEPTH = rf_depth(RF_DEF_NTHREADS, RF_DEF_AW);

  function automatic int unsigned rf_index(input int unsigned thr, input int unsigned r,
                                           input int unsigned aw);
    return (thr << aw) | r;
  endfunction

endpackage

// File: rtl/or1200_mt_rf_bank.sv
// Flat 2-write / NR-read storage array with registered, write-first read ports.
// Write port 1 has priority over port 0 when both target the same index.
module or1200_mt_rf_bank #(
  parameter int DEPTH = 256,
  parameter int IW    = 8,
  parameter int DW    = 32,
  parameter int NR    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we0,
  input  logic [IW-1:0]          wa0,
  input  logic [DW-1:0]          wd0,
  input  logic                   we1,
  input  logic [IW-1:0]          wa1,
  input  logic [DW-1:0]          wd1,
  input  logic [NR-1:0]          re,
  input  logic [NR-1:0]          rz,
  input  logic [NR-1:0][IW-1:0]  ra,
  output logic [NR-1:0][DW-1:0]  rd
);

  logic [DW-1:0] mem [DEPTH];

  // Later assignment wins, giving port 1 priority on a same-index collision.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  // rz forces a zero capture (register 0, or storage not yet initialised).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (re[i]) begin
          if (rz[i])                    rd[i] <= '0;
          else if (we1 && wa1 == ra[i]) rd[i] <= wd1;
          else if (we0 && wa0 == ra[i]) rd[i] <= wd0;
          else                          rd[i] <= mem[ra[i]];
        end
      end
    end
  end

endmodule

// File: rtl/or1200_mt_rf_gen.sv
// Multithreaded GPR file: NTHREADS contexts, 2 WB write ports, 4 ID read ports,
// SPR access port and a context-clear engine that runs after reset and on request.
module or1200_mt_rf_gen
  import or1200_mt_rf_pkg::*;
#(
  parameter int NTHREADS = 8,
  parameter int TW       = 3,
  parameter int AW       = 5,
  parameter int DW       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_freeze,
  input  logic             flushpipe,
  input  logic [TW-1:0]    thr_w,
  input  logic             we,
  input  logic             we2,
  input  logic [AW-1:0]    addrw,
  input  logic [AW-1:0]    addrw2,
  input  logic [DW-1:0]    dataw,
  input  logic [DW-1:0]    dataw2,
  input  logic             id_freeze,
  input  logic [TW-1:0]    thr_r,
  input  logic             rda,
  input  logic             rdb,
  input  logic             rda2,
  input  logic             rdb2,
  input  logic [AW-1:0]    addra,
  input  logic [AW-1:0]    addrb,
  input  logic [AW-1:0]    addra2,
  input  logic [AW-1:0]    addrb2,
  output logic [DW-1:0]    dataa,
  output logic [DW-1:0]    datab,
  output logic [DW-1:0]    dataa2,
  output logic [DW-1:0]    datab2,
  input  logic             spr_cs,
  input  logic             spr_write,
  input  logic [TW+AW-1:0] spr_addr,
  input  logic [DW-1:0]    spr_dat_i,
  output logic [DW-1:0]    spr_dat_o,
  output logic             spr_ack,
  input  logic             clr_req,
  input  logic [TW-1:0]    clr_thr,
  output logic             clr_busy,
  output logic             rf_ready,
  output logic [1:0]       fsm_state
);

  localparam int IW    = TW + AW;
  localparam int DEPTH = rf_depth(NTHREADS, AW);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  rf_state_e     state;
  logic [IW-1:0] cnt;
  logic [TW-1:0] clr_thr_q;

  assign fsm_state = state;

  logic wr_open, clr_hit_w, p0_act, p1_act, c0, c1;
  logic maint_on, maint_go, spr_acc, spr_wr;
  logic [IW-1:0] maint_idx, w0_idx, w1_idx;

  assign wr_open   = ~wb_freeze & ~flushpipe & rf_ready;
  assign clr_hit_w = (state == ST_CLEAR) && (thr_w == clr_thr_q);
  assign p0_act    = we  & wr_open;
  assign p1_act    = we2 & wr_open;
  assign c0        = p0_act & (addrw  != '0) & ~clr_hit_w;
  assign c1        = p1_act & (addrw2 != '0) & ~clr_hit_w;
  assign w0_idx    = IW'(rf_index(thr_w, addrw,  AW));
  assign w1_idx    = IW'(rf_index(thr_w, addrw2, AW));

  // The clear engine borrows whichever write port is free; it pauses only if
  // both ports commit to other threads in the same cycle.
  assign maint_on  = (state == ST_INIT) || (state == ST_CLEAR);
  assign maint_go  = maint_on & ~(c0 & c1);
  assign maint_idx = (state == ST_INIT) ? cnt
                                        : IW'(rf_index(clr_thr_q, cnt[AW-1:0], AW));

  // SPR handshake: the requester holds spr_cs (with address/direction/data
  // stable) until spr_ack. A request is accepted in a cycle where the FSM is
  // IDLE, no WB port write is committing and no ack is being returned; spr_ack
  // pulses for exactly one cycle on the edge after acceptance.
  assign spr_acc = spr_cs & (state == ST_IDLE) & ~p0_act & ~p1_act & ~spr_ack;
  assign spr_wr  = spr_acc & spr_write & (spr_addr[AW-1:0] != '0);

  logic          bwe0, bwe1;
  logic [IW-1:0] bwa0, bwa1;
  logic [DW-1:0] bwd0, bwd1;

  always_comb begin
    bwe0 = 1'b0;
    bwa0 = '0;
    bwd0 = '0;
    bwe1 = 1'b0;
    bwa1 = '0;
    bwd1 = '0;
    if (c0) begin
      bwe0 = 1'b1;
      bwa0 = w0_idx;
      bwd0 = dataw;
    end else if (spr_wr) begin
      bwe0 = 1'b1;
      bwa0 = spr_addr;
      bwd0 = spr_dat_i;
    end else if (maint_go) begin
      bwe0 = 1'b1;
      bwa0 = maint_idx;
    end
    if (c1) begin
      bwe1 = 1'b1;
      bwa1 = w1_idx;
      bwd1 = dataw2;
    end else if (maint_go && c0) begin
      bwe1 = 1'b1;
      bwa1 = maint_idx;
    end
  end

  // Read lanes 0..3 are the ID ports, lane 4 serves SPR reads.
  logic [4:0]         bre, brz;
  logic [4:0][IW-1:0] bra;
  logic [4:0][DW-1:0] brd;

  assign bre = {spr_acc & ~spr_write,
                rdb2 & ~id_freeze, rda2 & ~id_freeze,
                rdb  & ~id_freeze, rda  & ~id_freeze};

  assign bra[0] = IW'(rf_index(thr_r, addra,  AW));
  assign bra[1] = IW'(rf_index(thr_r, addrb,  AW));
  assign bra[2] = IW'(rf_index(thr_r, addra2, AW));
  assign bra[3] = IW'(rf_index(thr_r, addrb2, AW));
  assign bra[4] = spr_addr;

  assign brz[0] = ~rf_ready | (addra  == '0);
  assign brz[1] = ~rf_ready | (addrb  == '0);
  assign brz[2] = ~rf_ready | (addra2 == '0);
  assign brz[3] = ~rf_ready | (addrb2 == '0);
  assign brz[4] = ~rf_ready | (spr_addr[AW-1:0] == '0);

  or1200_mt_rf_bank #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .DW    (DW),
    .NR    (5)
  ) u_bank (
    .clk (clk),
    .rst (rst),
    .we0 (bwe0),
    .wa0 (bwa0),
    .wd0 (bwd0),
    .we1 (bwe1),
    .wa1 (bwa1),
    .wd1 (bwd1),
    .re  (bre),
    .rz  (brz),
    .ra  (bra),
    .rd  (brd)
  );

  assign dataa     = brd[0];
  assign datab     = brd[1];
  assign dataa2    = brd[2];
  assign datab2    = brd[3];
  assign spr_dat_o = brd[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      clr_thr_q <= '0;
      clr_busy  <= 1'b0;
      rf_ready  <= 1'b0;
      spr_ack   <= 1'b0;
    end else begin
      spr_ack <= spr_acc;
      case (state)
        ST_INIT: begin
          cnt      <= cnt + IW'(1);
          clr_busy <= 1'b1;
          if (cnt == LAST_IDX) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rf_ready <= 1'b1;
            clr_busy <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state     <= ST_CLEAR;
            clr_thr_q <= clr_thr;
            cnt       <= '0;
            clr_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (maint_go) begin
            cnt <= cnt + IW'(1);
            if (cnt[AW-1:0] == {AW{1'b1}}) begin
              state    <= ST_IDLE;
              cnt      <= '0;
              clr_busy <= 1'b0;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
